// File: rtl/ysyx_23060072_ifu_ctrl.sv
// Instruction fetch controller: issues one memory request at a time and
// queues fetched {pc, instr} pairs in a 2-entry FIFO toward decode. An
// EX-stage redirect flushes the FIFO. A request that is still outstanding
// when the redirect arrives has its response thrown away.
//
// state | meaning
// ------+-------------------------------------------------------------
// REQ   | no request outstanding; may issue when not halted, FIFO not full
// WAIT  | one request outstanding; its response is pushed into the FIFO
// DRAIN | one request outstanding; its response is stale and dropped
module ysyx_23060072_ifu_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        halt_i,
  output logic        id_valid_o,
  input  logic        id_ready_i,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_instr_o
);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [31:0] pc_q;
  logic [31:0] rec_pc_q;
  logic [31:0] fifo_pc_q    [2];
  logic [31:0] fifo_instr_q [2];
  logic        head_q;
  logic [1:0]  cnt_q;
  logic        tail;
  logic        issue;
  logic        push;
  logic        pop;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_REQ;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a redirect decides whether the in-flight response is kept
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_REQ: begin
        if (issue) begin
          state_d = redirect_i ? S_DRAIN : S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid_i) begin
          state_d = S_REQ;
        end else if (redirect_i) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (imem_rvalid_i) begin
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  // Outputs and handshake strobes; decode sees only the FIFO head (no bypass)
  always_comb begin
    imem_req_o  = (state_q == S_REQ) & ~halt_i & ~rst & (cnt_q != 2'd2);
    imem_addr_o = pc_q;
    issue       = imem_req_o & imem_gnt_i;
    push        = (state_q == S_WAIT) & imem_rvalid_i & ~redirect_i;
    id_valid_o  = (cnt_q != 2'd0) & ~rst;
    id_pc_o     = id_valid_o ? fifo_pc_q[head_q] : 32'h0;
    id_instr_o  = id_valid_o ? fifo_instr_q[head_q] : 32'h0;
    pop         = id_valid_o & id_ready_i & ~redirect_i;
    tail        = head_q ^ cnt_q[0];
  end

  // Fetch PC: redirect wins, otherwise advance on each accepted request
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else if (redirect_i) begin
      pc_q <= redirect_pc_i;
    end else if (issue) begin
      pc_q <= pc_q + 32'd4;
    end
  end

  // Remember the PC of the outstanding request to pair with its data
  always_ff @(posedge clk) begin
    if (rst) begin
      rec_pc_q <= RESET_PC;
    end else if (issue) begin
      rec_pc_q <= pc_q;
    end
  end

  // FIFO occupancy and head pointer; redirect empties the queue
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= 2'd0;
      head_q <= 1'b0;
    end else if (redirect_i) begin
      cnt_q  <= 2'd0;
    end else begin
      cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
      if (pop) begin
        head_q <= ~head_q;
      end
    end
  end

  // FIFO storage; a push never targets a full queue since only one request flies
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc_q[tail]    <= rec_pc_q;
      fifo_instr_q[tail] <= imem_rdata_i;
    end
  end

endmodule

// File: doc/ysyx_23060072_ifu_ctrl.md
YSYX_23060072_IFU_CTRL -- requirements
Module: ysyx_23060072_ifu_ctrl

Interface
REQ-001 SHALL provide parameter RESET_PC, default 32'h8000_0000, meaning the first fetch address after reset.
REQ-002 SHALL provide clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL provide rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL provide imem_req_o  output  1  fetch request to instruction memory.
REQ-005 SHALL provide imem_addr_o  output  32  fetch address, equal to the internal PC.
REQ-006 SHALL provide imem_gnt_i  input  1  request accepted this cycle.
REQ-007 SHALL provide imem_rvalid_i  input  1  read data valid; arrives 1 or more cycles after gnt.
REQ-008 SHALL provide imem_rdata_i  input  32  instruction word.
REQ-009 SHALL provide redirect_i  input  1  branch/jump redirect from EX.
REQ-010 SHALL provide redirect_pc_i  input  32  redirect target, word-aligned.
REQ-011 SHALL provide halt_i  input  1  suppresses new requests; does not cancel an outstanding request.
REQ-012 SHALL provide id_valid_o  output  1  instruction available to decode.
REQ-013 SHALL provide id_ready_i  input  1  decode accepts the head instruction.
REQ-014 SHALL provide id_pc_o  output  32  PC of the head instruction.
REQ-015 SHALL provide id_instr_o  output  32  head instruction word.

Function
REQ-016 SHALL implement a 3-state FSM: REQ (may issue), WAIT (one request outstanding, response wanted), DRAIN (one request outstanding, response to be discarded).
REQ-017 SHALL hold at most one outstanding memory request at any time.
REQ-018 SHALL assert imem_req_o only in REQ, with halt_i=0, rst=0 and buffer count < 2.
REQ-019 SHALL, in REQ on req&gnt without redirect: record the issued PC, set PC <= PC+4 (32-bit wrap-around modulo 2^32), go to WAIT.
REQ-020 SHALL permit imem_addr_o to change while req is asserted but ungranted.
REQ-021 SHALL, in WAIT on rvalid without redirect: push {recorded PC, rdata} into the buffer, go to REQ.
REQ-022 SHALL give redirect_i priority over all other events: PC <= redirect_pc_i, buffer flushed (count=0), id_valid_o=0 the following cycle.
REQ-023 SHALL, on redirect in REQ without gnt: stay in REQ, next request uses the redirect target.
REQ-024 SHALL, on redirect coincident with gnt in REQ, or in WAIT without rvalid: go to DRAIN.
REQ-025 SHALL, on redirect coincident with rvalid in WAIT: discard the data, go to REQ.
REQ-026 SHALL, in DRAIN on rvalid: discard the data, go to REQ; a further redirect in DRAIN updates PC only.
REQ-027 SHALL ignore imem_rvalid_i in REQ.
REQ-028 SHALL implement a 2-entry FIFO; outputs driven from the head entry, no bypass.
REQ-029 SHALL pop the FIFO on id_valid_o & id_ready_i; a simultaneous push and pop leaves count unchanged.
REQ-030 SHALL make pushed data visible on id_* the cycle after the rvalid cycle; with 1-cycle memory latency, throughput is 1 instruction per 2 cycles.
REQ-031 SHALL hold id_pc_o and id_instr_o stable while id_valid_o=1 and id_ready_i=0.

Reset
REQ-032 SHALL, while rst=1 at a clock edge: state <= REQ, PC <= RESET_PC, FIFO count <= 0; imem_req_o=0, id_valid_o=0, id_pc_o=0, id_instr_o=0.
REQ-033 SHALL abandon an outstanding request on reset mid-operation; any later rvalid arrives in REQ and is ignored (REQ-027).
REQ-034 SHALL assert imem_req_o with addr=RESET_PC in the first cycle after rst deasserts, given halt_i=0.

Verification
REQ-035 SHALL cover: reset release, gnt always 1, rvalid 1 cycle after gnt, id_ready=1 -> addresses 8000_0000, 8000_0004, 8000_0008 on alternating cycles; id_pc_o follows in order.
REQ-036 SHALL cover: id_ready=0 for 10 cycles -> exactly 2 instructions buffered, imem_req_o=0 afterwards, id outputs stable; ready=1 -> both delivered in order, fetch resumes at 8000_0008.
REQ-037 SHALL cover: redirect to 8000_0100 in the same cycle as gnt for 8000_0004 -> that response discarded, next request to 8000_0100, FIFO empty.
REQ-038 SHALL cover: redirect to 8000_0200 in the same cycle as rvalid, with one entry buffered -> data dropped, id_valid_o=0 next cycle, next request to 8000_0200.
REQ-039 SHALL cover: PC = FFFF_FFFC granted -> next request address 0000_0000.
REQ-040 SHALL cover: rst asserted in WAIT, late rvalid after release -> ignored, request to RESET_PC, no instruction pushed.
